// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
// State encoding and reset/bubble defaults.
package fetch_stage_pkg;

    typedef logic [1:0] fetchState_t;

    localparam fetchState_t FETCH = 2'd0;
    localparam fetchState_t HOLD  = 2'd1;
    localparam fetchState_t DRAIN = 2'd2;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

    function automatic logic [31:0] wordAlign(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, handshakes with imem,
// buffers one instruction across stalls and drains on redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic [31:0] IMemRData,
    output logic [31:0] NPCOut,
    output logic [31:0] InstrOut,
    output logic        ValidOut
);

    fetchState_t state, stateNext;
    logic [31:0] pc, pcNext;
    logic [31:0] target, targetNext;
    logic [31:0] bufInstr, bufInstrNext;
    logic [31:0] bufNpc, bufNpcNext;
    logic [31:0] pcPlus4;
    logic [31:0] redirAddr;

    assign pcPlus4   = pc + 32'd4;
    assign redirAddr = wordAlign(RedirectPC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            target   <= '0;
            bufInstr <= '0;
            bufNpc   <= '0;
        end else begin
            state    <= stateNext;
            pc       <= pcNext;
            target   <= targetNext;
            bufInstr <= bufInstrNext;
            bufNpc   <= bufNpcNext;
        end
    end

    always_comb begin
        stateNext    = state;
        pcNext       = pc;
        targetNext   = target;
        bufInstrNext = bufInstr;
        bufNpcNext   = bufNpc;
        unique case (state)
            FETCH: begin
                if (Redirect) begin
                    if (IMemReady) begin
                        pcNext = redirAddr;
                    end else begin
                        targetNext = redirAddr;
                        stateNext  = DRAIN;
                    end
                end else if (IMemReady) begin
                    pcNext = pcPlus4;
                    if (Stall) begin
                        bufInstrNext = IMemRData;
                        bufNpcNext   = pcPlus4;
                        stateNext    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (Redirect) begin
                    pcNext    = redirAddr;
                    stateNext = FETCH;
                end else if (!Stall) begin
                    stateNext = FETCH;
                end
            end
            DRAIN: begin
                // The in-flight request must complete before the new PC issues.
                if (Redirect) begin
                    targetNext = redirAddr;
                end
                if (IMemReady) begin
                    pcNext    = Redirect ? redirAddr : target;
                    stateNext = FETCH;
                end
            end
            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    always_comb begin
        IMemReq  = 1'b0;
        IMemAddr = wordAlign(pc);
        ValidOut = 1'b0;
        InstrOut = NOP_INSTR;
        NPCOut   = '0;
        if (rst_n) begin
            unique case (state)
                FETCH: begin
                    IMemReq = 1'b1;
                    if (IMemReady && !Redirect) begin
                        ValidOut = 1'b1;
                        InstrOut = IMemRData;
                        NPCOut   = pcPlus4;
                    end
                end
                HOLD: begin
                    if (!Redirect) begin
                        ValidOut = 1'b1;
                        InstrOut = bufInstr;
                        NPCOut   = bufNpc;
                    end
                end
                DRAIN: begin
                    IMemReq = 1'b1;
                end
                default: begin
                    IMemReq = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: zero-wait, wait states, stall/hold,
// redirect/drain, address wrap and mid-request reset.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic [31:0] IMemRData;
    logic [31:0] NPCOut;
    logic [31:0] InstrOut;
    logic        ValidOut;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Stall     (Stall),
        .Redirect  (Redirect),
        .RedirectPC(RedirectPC),
        .IMemReq   (IMemReq),
        .IMemAddr  (IMemAddr),
        .IMemReady (IMemReady),
        .IMemRData (IMemRData),
        .NPCOut    (NPCOut),
        .InstrOut  (InstrOut),
        .ValidOut  (ValidOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic [31:0] rdata,
                         input logic stl, input logic redir,
                         input logic [31:0] rpc);
        IMemReady  = rdy;
        IMemRData  = rdata;
        Stall      = stl;
        Redirect   = redir;
        RedirectPC = rpc;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
        chk("rst_req", {31'b0, IMemReq}, 32'h0);
        chk("rst_valid", {31'b0, ValidOut}, 32'h0);
        chk("rst_instr", InstrOut, 32'h0);
        chk("rst_npc", NPCOut, 32'h0);
        tick();
        rst_n = 1'b1;

        // zero-wait memory
        drive(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
        chk("zw0_addr", IMemAddr, 32'h3000);
        chk("zw0_req", {31'b0, IMemReq}, 32'h1);
        chk("zw0_valid", {31'b0, ValidOut}, 32'h1);
        chk("zw0_instr", InstrOut, 32'h3000);
        chk("zw0_npc", NPCOut, 32'h3004);
        tick();
        drive(1'b1, 32'h3004, 1'b0, 1'b0, 32'h0);
        chk("zw1_addr", IMemAddr, 32'h3004);
        chk("zw1_instr", InstrOut, 32'h3004);
        chk("zw1_npc", NPCOut, 32'h3008);
        tick();
        drive(1'b1, 32'h3008, 1'b0, 1'b0, 32'h0);
        chk("zw2_valid", {31'b0, ValidOut}, 32'h1);
        chk("zw2_instr", InstrOut, 32'h3008);
        chk("zw2_npc", NPCOut, 32'h300C);
        tick();

        // two wait states
        doReset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("ws0_valid", {31'b0, ValidOut}, 32'h0);
        chk("ws0_addr", IMemAddr, 32'h3000);
        chk("ws0_instr", InstrOut, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("ws1_valid", {31'b0, ValidOut}, 32'h0);
        chk("ws1_addr", IMemAddr, 32'h3000);
        tick();
        drive(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
        chk("ws2_valid", {31'b0, ValidOut}, 32'h1);
        chk("ws2_addr", IMemAddr, 32'h3000);
        chk("ws2_instr", InstrOut, 32'h3000);
        tick();

        // stall 3 cycles with ready at 0x3004
        drive(1'b1, 32'h3004, 1'b1, 1'b0, 32'h0);
        chk("st0_addr", IMemAddr, 32'h3004);
        chk("st0_instr", InstrOut, 32'h3004);
        chk("st0_npc", NPCOut, 32'h3008);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("st1_req", {31'b0, IMemReq}, 32'h0);
        chk("st1_valid", {31'b0, ValidOut}, 32'h1);
        chk("st1_instr", InstrOut, 32'h3004);
        chk("st1_npc", NPCOut, 32'h3008);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("st2_req", {31'b0, IMemReq}, 32'h0);
        chk("st2_instr", InstrOut, 32'h3004);
        chk("st2_npc", NPCOut, 32'h3008);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("st3_valid", {31'b0, ValidOut}, 32'h1);
        chk("st3_instr", InstrOut, 32'h3004);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("st4_req", {31'b0, IMemReq}, 32'h1);
        chk("st4_addr", IMemAddr, 32'h3008);
        chk("st4_valid", {31'b0, ValidOut}, 32'h0);
        tick();

        // redirect in FETCH with ready
        drive(1'b1, 32'h3008, 1'b0, 1'b1, 32'h3402);
        chk("rd0_valid", {31'b0, ValidOut}, 32'h0);
        chk("rd0_instr", InstrOut, 32'h0);
        tick();
        drive(1'b1, 32'h3400, 1'b0, 1'b1, 32'h3010);
        chk("rd1_addr", IMemAddr, 32'h3400);
        chk("rd1_valid", {31'b0, ValidOut}, 32'h0);
        tick();

        // redirect during 3-cycle wait at 0x3010
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h4000);
        chk("dr0_addr", IMemAddr, 32'h3010);
        chk("dr0_valid", {31'b0, ValidOut}, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("dr1_req", {31'b0, IMemReq}, 32'h1);
        chk("dr1_addr", IMemAddr, 32'h3010);
        tick();
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        chk("dr2_addr", IMemAddr, 32'h3010);
        chk("dr2_valid", {31'b0, ValidOut}, 32'h0);
        chk("dr2_instr", InstrOut, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("dr3_addr", IMemAddr, 32'h4000);
        tick();

        // second redirect during drain
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h4800);
        chk("dd0_addr", IMemAddr, 32'h4000);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h5000);
        chk("dd1_addr", IMemAddr, 32'h4000);
        chk("dd1_valid", {31'b0, ValidOut}, 32'h0);
        tick();
        drive(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0);
        chk("dd2_valid", {31'b0, ValidOut}, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("dd3_addr", IMemAddr, 32'h5000);
        tick();

        // redirect + stall while in HOLD
        drive(1'b1, 32'hAAAA_0001, 1'b1, 1'b0, 32'h0);
        chk("hr0_instr", InstrOut, 32'hAAAA_0001);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h6000);
        chk("hr1_valid", {31'b0, ValidOut}, 32'h0);
        chk("hr1_instr", InstrOut, 32'h0);
        chk("hr1_npc", NPCOut, 32'h0);
        chk("hr1_req", {31'b0, IMemReq}, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("hr2_req", {31'b0, IMemReq}, 32'h1);
        chk("hr2_addr", IMemAddr, 32'h6000);
        tick();

        // wrap at top of address space
        drive(1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("wr0_addr", IMemAddr, 32'hFFFF_FFFC);
        tick();
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
        chk("wr1_valid", {31'b0, ValidOut}, 32'h1);
        chk("wr1_npc", NPCOut, 32'h0);
        chk("wr1_instr", InstrOut, 32'h1234_5678);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("wr2_addr", IMemAddr, 32'h0);
        chk("wr2_req", {31'b0, IMemReq}, 32'h1);
        tick();

        // reset during a wait
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("mr0_req", {31'b0, IMemReq}, 32'h0);
        chk("mr0_valid", {31'b0, ValidOut}, 32'h0);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("mr1_req", {31'b0, IMemReq}, 32'h1);
        chk("mr1_addr", IMemAddr, 32'h3000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
